mult_seq_param: RTL and testbench

//  Parametrised sequential multiplier: A_W x B_W operands, one A_CHUNK x B_CHUNK partial

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_pp_slice.sv | 46 ++++
 rtl/mult_seq_param.sv | 140 ++++++++++++++
 tb/tb_mult_seq_param.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM state type and sizing helpers for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic int chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index registers never collapse to zero width, even for a single chunk.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_pp_slice.sv
// rtl/mult_pp_slice.sv - selects one a/b chunk pair, multiplies it and aligns it in product space
module mult_pp_slice
    import mult_pkg::*;
#(
    parameter int A_W     = 32,
    parameter int B_W     = 32,
    parameter int A_CHUNK = 8,
    parameter int B_CHUNK = 16,
    localparam int NA     = chunks(A_W, A_CHUNK),
    localparam int NB     = chunks(B_W, B_CHUNK),
    localparam int IW     = idx_w(NA),
    localparam int JW     = idx_w(NB),
    localparam int P_W    = A_W + B_W
) (
    input  logic [A_W-1:0] a_mag,
    input  logic [B_W-1:0] b_mag,
    input  logic [IW-1:0]  i_idx,
    input  logic [JW-1:0]  j_idx,
    output logic [P_W-1:0] pp
);

    localparam int PP_W = A_CHUNK + B_CHUNK;

    logic [A_CHUNK-1:0] a_sl;
    logic [B_CHUNK-1:0] b_sl;
    logic [PP_W-1:0]    prod;

    always_comb begin
        a_sl = '0;
        for (int k = 0; k < NA; k++) begin
            if (i_idx == IW'(k)) a_sl = a_mag[k*A_CHUNK +: A_CHUNK];
        end
    end

    always_comb begin
        b_sl = '0;
        for (int k = 0; k < NB; k++) begin
            if (j_idx == JW'(k)) b_sl = b_mag[k*B_CHUNK +: B_CHUNK];
        end
    end

    // Operands widened to the partial-product width so the multiply never truncates.
    assign prod = {{B_CHUNK{1'b0}}, a_sl} * {{A_CHUNK{1'b0}}, b_sl};
    assign pp   = P_W'(prod) << (i_idx * A_CHUNK + j_idx * B_CHUNK);

endmodule

// File: rtl/mult_seq_param.sv
// rtl/mult_seq_param.sv - sequential signed/unsigned multiplier, one chunk product per cycle
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int A_W     = 32,
    parameter int B_W     = 32,
    parameter int A_CHUNK = 8,
    parameter int B_CHUNK = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               in_ready,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic               is_signed,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] product
);

    localparam int NA  = chunks(A_W, A_CHUNK);
    localparam int NB  = chunks(B_W, B_CHUNK);
    localparam int N   = NA * NB;
    localparam int IW  = idx_w(NA);
    localparam int JW  = idx_w(NB);
    localparam int CW  = idx_w(N);
    localparam int P_W = A_W + B_W;

    if (A_W % A_CHUNK != 0) begin : g_bad_a_chunk
        $error("mult_seq_param: A_W must be a multiple of A_CHUNK");
    end
    if (B_W % B_CHUNK != 0) begin : g_bad_b_chunk
        $error("mult_seq_param: B_W must be a multiple of B_CHUNK");
    end

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [IW-1:0]  i_q;
    logic [JW-1:0]  j_q;
    logic [A_W-1:0] a_mag_q;
    logic [B_W-1:0] b_mag_q;
    logic           neg_q;
    logic [P_W-1:0] acc_q;
    logic [P_W-1:0] product_q;
    logic           out_valid_q;
    logic [P_W-1:0] pp;
    logic           accept;

    mult_pp_slice #(
        .A_W     (A_W),
        .B_W     (B_W),
        .A_CHUNK (A_CHUNK),
        .B_CHUNK (B_CHUNK)
    ) u_pp_slice (
        .a_mag (a_mag_q),
        .b_mag (b_mag_q),
        .i_idx (i_q),
        .j_idx (j_q),
        .pp    (pp)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = start;
                if (start) state_d = CALC;
            end
            CALC: if (cnt_q == CW'(N - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Work on magnitudes; the sign is reapplied once in FIX.
                        a_mag_q <= (is_signed && a[A_W-1]) ? -a : a;
                        b_mag_q <= (is_signed && b[B_W-1]) ? -b : b;
                        neg_q   <= is_signed & (a[A_W-1] ^ b[B_W-1]);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_q + pp;
                    cnt_q <= cnt_q + CW'(1);
                    if (i_q == IW'(NA - 1)) begin
                        i_q <= '0;
                        j_q <= j_q + JW'(1);
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                FIX: begin
                    product_q   <= neg_q ? -acc_q : acc_q;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// tb/tb_mult_seq_param.sv - scoreboard bench for default and narrow multiplier configurations
module tb_mult_seq_param;

    localparam int N0 = 8;
    localparam int N1 = 4;

    typedef struct {
        logic [63:0] p;
        int          acc;
    } exp_t;

    logic        clk;
    logic        reset;
    int          cyc;
    int          total;
    int          bad;
    bit          rnd_ready;

    logic        start0, s0, in_ready0, busy0, out_valid0, out_ready0;
    logic [31:0] a0, b0;
    logic [63:0] product0;

    logic        start1, s1, in_ready1, busy1, out_valid1, out_ready1;
    logic [15:0] a1;
    logic [7:0]  b1;
    logic [23:0] product1;

    exp_t q0[$];
    exp_t q1[$];
    logic pv0, pv1;

    mult_seq_param dut0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start0),
        .in_ready  (in_ready0),
        .a         (a0),
        .b         (b0),
        .is_signed (s0),
        .busy      (busy0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .product   (product0)
    );

    mult_seq_param #(
        .A_W     (16),
        .B_W     (8),
        .A_CHUNK (4),
        .B_CHUNK (8)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .is_signed (s1),
        .busy      (busy1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .product   (product1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid0 && !pv0 && q0.size() != 0)
                chk("latency0", 64'(cyc - q0[0].acc), 64'(N0 + 1));
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) chk("unexpected_out0", 64'd1, 64'd0);
                else chk("product0", product0, q0.pop_front().p);
            end
            if (out_valid1 && !pv1 && q1.size() != 0)
                chk("latency1", 64'(cyc - q1[0].acc), 64'(N1 + 1));
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) chk("unexpected_out1", 64'd1, 64'd0);
                else chk("product1", {40'd0, product1}, q1.pop_front().p);
            end
        end
        pv0 = out_valid0;
        pv1 = out_valid1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready0 = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] e, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) begin
            chk("issue0_timeout", 64'd0, 64'd1);
            return;
        end
        start0 = 1'b1;
        a0 = a;
        b0 = b;
        s0 = s;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        if (push) q0.push_back('{p: e, acc: cyc});
    endtask

    task automatic issue1(input logic [15:0] a, input logic [7:0] b, input logic s,
                          input logic [23:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready1) begin
            chk("issue1_timeout", 64'd0, 64'd1);
            return;
        end
        start1 = 1'b1;
        a1 = a;
        b1 = b;
        s1 = s;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        q1.push_back('{p: {40'd0, e}, acc: cyc});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !in_ready0 || !in_ready1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid0();
        int n;
        n = 0;
        while (!out_valid0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("valid0_rise", {63'd0, out_valid0}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        total = 0;
        bad = 0;
        rnd_ready = 1'b0;
        pv0 = 1'b0;
        pv1 = 1'b0;
        reset = 1'b1;
        start0 = 1'b0; a0 = '0; b0 = '0; s0 = 1'b0; out_ready0 = 1'b1;
        start1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready0", {63'd0, in_ready0}, 64'd1);
        chk("rst_busy0", {63'd0, busy0}, 64'd0);
        chk("rst_valid0", {63'd0, out_valid0}, 64'd0);
        chk("rst_product0", product0, 64'd0);
        chk("rst_in_ready1", {63'd0, in_ready1}, 64'd1);
        chk("rst_product1", {40'd0, product1}, 64'd0);

        // Full-scale unsigned, single-cycle valid with out_ready high
        issue0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_valid0();
        @(negedge clk);
        chk("valid0_one_cycle", {63'd0, out_valid0}, 64'd0);
        wait_idle();

        // Signed and unsigned interpretations of the same bits
        issue0(32'hFFFF_FFFF, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
        issue0(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        issue0(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1);
        issue0(32'h8000_0000, 32'd1, 1'b0, 64'h0000_0000_8000_0000, 1'b1);
        issue0(32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        issue0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, 1'b1);
        issue0(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        issue0(32'd0, 32'hFFFF_FFFF, 1'b1, 64'd0, 1'b1);
        wait_idle();

        // Backpressure in DONE with start pulses that must be ignored
        out_ready0 = 1'b0;
        issue0(32'd3, 32'd4, 1'b0, 64'd12, 1'b1);
        wait_valid0();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {63'd0, out_valid0}, 64'd1);
            chk("bp_product", product0, 64'd12);
            chk("bp_in_ready", {63'd0, in_ready0}, 64'd0);
            @(posedge clk);
            #1;
            start0 = 1'b1;
            a0 = 32'd9;
            b0 = 32'd9;
            @(negedge clk);
        end
        chk("bp_product_end", product0, 64'd12);
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(negedge clk);
        chk("bp_back_idle", {63'd0, in_ready0}, 64'd1);
        chk("bp_not_busy", {63'd0, busy0}, 64'd0);
        wait_idle();

        // Reset in the middle of CALC drops the operation and clears the result
        issue0(32'd10, 32'd10, 1'b0, 64'd100, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, in_ready0}, 64'd1);
        chk("midrst_busy", {63'd0, busy0}, 64'd0);
        chk("midrst_valid", {63'd0, out_valid0}, 64'd0);
        chk("midrst_product", product0, 64'd0);
        issue0(32'd3, 32'd7, 1'b0, 64'd21, 1'b1);
        wait_idle();

        // Narrow configuration
        issue1(16'hABCD, 8'h12, 1'b0, 24'h0C_146A);
        issue1(16'hFFFF, 8'h03, 1'b1, 24'hFF_FFFD);
        issue1(16'h8000, 8'h80, 1'b1, 24'h40_0000);
        issue1(16'hFFFF, 8'hFF, 1'b0, 24'hFE_FF01);
        wait_idle();

        // Back-to-back random traffic with random consumer stalls
        rnd_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (k % 7 == 0) ra = 32'h8000_0000;
            if (k % 5 == 0) rb = 32'hFFFF_FFFF;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue0(ra, rb, rs, model(ra, rb, rs), 1'b1);
        end
        wait_idle();
        rnd_ready = 1'b0;
        out_ready0 = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
